// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and request types for the register bank write path
package regfile_pkg;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef logic [WIDTH-1:0] reg_word_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    reg_word_t     data;
  } wr_req_t;
endpackage

// File: rtl/decoder5to32.sv
// rtl/decoder5to32.sv - 5-bit select to 32-bit one-hot decoder, all zeros when disabled
module decoder5to32 (
  input  logic        enable,
  input  logic [4:0]  sel,
  output logic [31:0] out
);
  always_comb begin
    out = '0;
    if (enable) out[sel] = 1'b1;
  end
endmodule

// File: rtl/register_writer.sv
// rtl/register_writer.sv - queues register write requests and retires one per cycle
// as a one-hot load enable plus shared load data for the register bank.
module register_writer
  import regfile_pkg::*;
#(
  parameter int WIDTH = regfile_pkg::WIDTH,
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW    = regfile_pkg::AW,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [NREGS-1:0] ld_en,
  output logic [WIDTH-1:0] ld_data,
  output logic [2:0]       count,
  output logic             busy,
  output logic [7:0]       r0_drops
);
  localparam int         PW      = $clog2(DEPTH);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  wr_req_t          fifo_q [DEPTH];
  wr_req_t          fifo_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [NREGS-1:0] ld_en_q, ld_en_d;
  logic [WIDTH-1:0] ld_data_q, ld_data_d;
  logic [7:0]       r0_drops_q, r0_drops_d;

  logic             push, pop, head_is_r0;
  wr_req_t          head;
  logic [NREGS-1:0] dec_out;

  assign wr_ready   = !reset && (count_q < DEPTH_C);
  assign push       = wr_valid && wr_ready;
  assign pop        = (count_q != 3'd0);
  assign head       = fifo_q[rd_ptr_q];
  assign head_is_r0 = (head.addr == '0);

  // R0 is hard-wired zero in the bank, so its writes retire with no enable.
  decoder5to32 u_decoder (
    .enable (pop && !head_is_r0),
    .sel    (head.addr),
    .out    (dec_out)
  );

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ld_en_d    = dec_out;
    ld_data_d  = ld_data_q;
    r0_drops_d = r0_drops_q;

    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: wr_addr, data: wr_data};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      ld_data_d = head.data;
      if (head_is_r0 && r0_drops_q != 8'hFF) r0_drops_d = r0_drops_q + 8'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ld_en_q    <= '0;
      ld_data_q  <= '0;
      r0_drops_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ld_en_q    <= ld_en_d;
      ld_data_q  <= ld_data_d;
      r0_drops_q <= r0_drops_d;
    end
  end

  assign ld_en    = ld_en_q;
  assign ld_data  = ld_data_q;
  assign count    = count_q;
  assign r0_drops = r0_drops_q;
  assign busy     = (count_q != 3'd0) || (ld_en_q != '0);
endmodule
